// File: rtl/latch_bank_wr_ctrl_pkg.sv
// Shared state encodings and defaults for the latch-bank write sequencer.
package latch_bank_wr_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_ENABLE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_ACK    = 3'd4
    } state_t;

    localparam int DEFAULT_EN_CYCLES = 1;

endpackage

// File: rtl/latch_bank_wr_ctrl_word.sv
// One level-sensitive storage word: transparent while en is high, holds otherwise.
module mux_latch_word #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] d,
    input  logic             en,
    output logic [WIDTH-1:0] q
);

    always_latch begin
        if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/latch_bank_wr_ctrl.sv
// Two-port round-robin write sequencer for a bank of D latches with a combinational read port.
// Optional macro LATCH_WR_CHECK_EN adds the wr_err write-verify output.
module latch_bank_wr_ctrl
    import latch_bank_wr_ctrl_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int ADDR_W    = 2,
    parameter int EN_CYCLES = DEFAULT_EN_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [WIDTH-1:0]  data0,
    output logic              ack0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [WIDTH-1:0]  data1,
    output logic              ack1,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data,
    output logic              busy
`ifdef LATCH_WR_CHECK_EN
    ,
    output logic              wr_err
`endif
);

    localparam int NWORDS = 2**ADDR_W;

    state_t            state_reg, state_next;
    logic [3:0]        cnt_reg, cnt_next;
    logic              grant_reg, grant_next;
    logic              last_grant_reg, last_grant_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [WIDTH-1:0]  d_bus_reg, d_bus_next;
    logic [DEPTH-1:0]  en_reg, en_next;
    logic [DEPTH-1:0]  en_decode;
    logic              ack0_reg, ack0_next;
    logic              ack1_reg, ack1_next;
    logic              win;
    logic [WIDTH-1:0]  words [NWORDS];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_dec
            assign en_decode[gi] = (addr_reg == ADDR_W'(gi));
        end
    endgenerate

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        grant_next      = grant_reg;
        last_grant_next = last_grant_reg;
        addr_next       = addr_reg;
        d_bus_next      = d_bus_reg;
        win             = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (req0 || req1) begin
                    // With both pending, the port that did not win last time goes first.
                    win             = (req0 && req1) ? ~last_grant_reg : req1;
                    grant_next      = win;
                    last_grant_next = win;
                    addr_next       = win ? addr1 : addr0;
                    d_bus_next      = win ? data1 : data0;
                    state_next      = ST_SETUP;
                end
            end
            ST_SETUP: begin
                cnt_next   = 4'(EN_CYCLES - 1);
                state_next = ST_ENABLE;
            end
            ST_ENABLE: begin
                if (cnt_reg == 4'd0) begin
                    state_next = ST_HOLD;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            ST_HOLD:  state_next = ST_ACK;
            ST_ACK:   state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Enables and acks are decoded from the next state so they register glitch-free in step with it.
    always_comb begin
        en_next   = (state_next == ST_ENABLE) ? en_decode : '0;
        ack0_next = (state_next == ST_ACK) && !grant_reg;
        ack1_next = (state_next == ST_ACK) && grant_reg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= 4'd0;
            grant_reg      <= 1'b0;
            last_grant_reg <= 1'b1;
            addr_reg       <= '0;
            d_bus_reg      <= '0;
            en_reg         <= '0;
            ack0_reg       <= 1'b0;
            ack1_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            grant_reg      <= grant_next;
            last_grant_reg <= last_grant_next;
            addr_reg       <= addr_next;
            d_bus_reg      <= d_bus_next;
            en_reg         <= en_next;
            ack0_reg       <= ack0_next;
            ack1_reg       <= ack1_next;
        end
    end

    // Unpopulated address slots read back as zero.
    generate
        for (gi = 0; gi < NWORDS; gi++) begin : g_word
            if (gi < DEPTH) begin : g_lat
                mux_latch_word #(.WIDTH(WIDTH)) u_word (
                    .d  (d_bus_reg),
                    .en (en_reg[gi]),
                    .q  (words[gi])
                );
            end else begin : g_pad
                assign words[gi] = '0;
            end
        end
    endgenerate

    assign rd_data = words[rd_addr];
    assign ack0    = ack0_reg;
    assign ack1    = ack1_reg;
    assign busy    = (state_reg != ST_IDLE);

`ifdef LATCH_WR_CHECK_EN
    logic addr_ok;
    logic wr_err_reg, wr_err_next;

    assign addr_ok     = (int'(addr_reg) < DEPTH);
    assign wr_err_next = (state_reg == ST_HOLD) && (!addr_ok || (words[addr_reg] != d_bus_reg));

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_err_reg <= 1'b0;
        end else begin
            wr_err_reg <= wr_err_next;
        end
    end

    assign wr_err = wr_err_reg;
`endif

endmodule
